bcd_timer_chain: RTL and testbench
==================================

Name: bcd_timer_chain

Overview:
Parametrised chain of BCD digits with per-digit modulus, counting up or down on a qualified tick. It supports run-time load, a wrap or saturate end mode, a terminal-count level and a one-cycle expiry pulse. It replaces fixed six-digit up-only game-time counters and serves both the elapsed-time display and countdown timers (fuel, race time). Outputs feed the seven-segment/HUD digit decoders and the game-control FSM.

Parameters:
DIGITS, 6, number of BCD digits (1..8); digit 0 is the least significant, count[3:0].
DIGIT_MAX, 32'h00995959, packed 4 bits per digit, max value of each digit (1..9); default gives digit0=9, digit1=5, digit2=9, digit3=5, digit4=9, digit5=9.
LOAD_VALUE, 32'h00000100, packed reset value per digit (digit2=1).
WRAP, 0, 1 = wrap at terminal; 0 = saturate and expire.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
loadN  in  1  synchronous active-low load of ld_data
ld_data  in  4*DIGITS  packed BCD load value
enable1  in  1  count qualifier (game running)
enable2  in  1  count qualifier (not paused)
tick  in  1  one-cycle count strobe (time base)
up  in  1  1 = count up, 0 = count down
count  out  4*DIGITS  packed BCD count, registered
tc  out  1  combinational: count is at terminal for the current direction
done  out  1  registered one-cycle expiry/terminal pulse
expired  out  1  registered: FSM is in EXPIRED

Behaviour:
- Reset (resetN=0, async): count=LOAD_VALUE, state=RUN, done=0, expired=0.
- The count strobe is step = tick & enable1 & enable2, sampled on the rising edge of clk.
- Terminal value: all digits = DIGIT_MAX when up=1; all digits = 0 when up=0. tc reflects the current count and up with no delay.
- Priority per cycle: loadN=0 > step > hold.
- Load:
  - Every digit takes the value of ld_data. A nibble greater than that digit's DIGIT_MAX is clamped to DIGIT_MAX.
  - state=RUN, expired=0, done=0. Load takes one cycle and is honoured in any state.
- Up step:
  - Digit i increments if every lower digit is at its DIGIT_MAX (ripple carry, single cycle).
  - Each carrying digit rolls DIGIT_MAX to 0.
- Down step:
  - Digit i decrements if every lower digit is 0.
  - Each borrowing digit rolls 0 to DIGIT_MAX.
- Step while not at terminal:
  - count updates.
  - If the new count equals terminal, done=1 for the following cycle (registered).
- Step while already at terminal, WRAP=1:
  - Up wraps to all 0; down wraps to all DIGIT_MAX.
  - No done pulse.
- Step while already at terminal, WRAP=0, state RUN:
  - count holds; state goes to EXPIRED; expired=1.
  - done pulses only if it did not pulse on reaching terminal. Track this with an internal flag set by the done pulse and cleared by load or by leaving terminal.
- State machine: two states, RUN and EXPIRED.
  - RUN to EXPIRED: only as above.
  - EXPIRED to RUN: only by load or reset.
  - In EXPIRED, steps are ignored and count holds.
  - With WRAP=1, EXPIRED is unreachable and expired stays 0.
- Direction change: up is sampled each step and takes effect on the next step. tc re-evaluates immediately.
- Disabled: if tick arrives with either enable low, count holds. The tick is not remembered.
- done is never asserted for more than one consecutive cycle. It is 0 during reset and in the load cycle.
- Elaboration check: any DIGIT_MAX nibble of 0 or >9, or any LOAD_VALUE nibble greater than its max, is a fatal error.

Test Plan:
- Reset with default parameters -> count=24'h000100, tc=0, done=0, expired=0. Assert resetN mid-step -> count returns to 24'h000100 asynchronously.
- Up carry: load 24'h005959, up=1, one step -> 24'h010000. Load 24'h995959, up=1, step -> count holds, tc=1, expired=1, done high for exactly one cycle.
- Countdown: load 24'h000002, up=0, three steps -> 000001, then 000000 with done pulse and tc=1, then expired=1 with no second done pulse. Further steps -> count holds. Load 24'h000030 -> expired=0, state RUN.
- WRAP=1, down from 24'h000000, step -> 24'h995959, done=0. Up from 24'h995959, step -> 24'h000000.
- Gating: enable2=0 across 5 ticks -> count unchanged. loadN=0 and step in the same cycle -> load wins.
- Clamp: load ld_data=24'h007A8F -> count=24'h005959. DIGITS=2, DIGIT_MAX=8'h59: 59 up-step saturates and expires at 59.

Source files
------------

// File: rtl/bcd_timer_chain.sv
// Chain of BCD digits with per-digit modulus, counting up or down on a qualified tick.
// It can saturate and expire at terminal or wrap, and produces a terminal level and a one-cycle done pulse.
module bcd_timer_chain #(
    parameter int          DIGITS     = 6,
    parameter logic [31:0] DIGIT_MAX  = 32'h00995959,
    parameter logic [31:0] LOAD_VALUE = 32'h00000100,
    parameter bit          WRAP       = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  loadN,
    input  logic [4*DIGITS-1:0]   ld_data,
    input  logic                  enable1,
    input  logic                  enable2,
    input  logic                  tick,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  done,
    output logic                  expired
);
    localparam int W = 4 * DIGITS;

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $fatal(1, "bcd_timer_chain: DIGITS must be 1..8");
        end
        for (genvar g = 0; g < DIGITS; g++) begin : g_chk
            if (DIGIT_MAX[4*g +: 4] == 4'd0 || DIGIT_MAX[4*g +: 4] > 4'd9) begin : g_bad_max
                $fatal(1, "bcd_timer_chain: DIGIT_MAX nibble out of range 1..9");
            end
            if (LOAD_VALUE[4*g +: 4] > DIGIT_MAX[4*g +: 4]) begin : g_bad_load
                $fatal(1, "bcd_timer_chain: LOAD_VALUE nibble exceeds DIGIT_MAX");
            end
        end
    endgenerate

    typedef enum logic {S_RUN, S_EXPIRED} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   max_val, rst_val;
    logic [W-1:0]   count_nxt, inc_val, dec_val, clamp_val;
    logic           carry, borrow;
    logic           step, at_max, at_zero;
    logic           flag, flag_nxt, done_nxt;

    assign max_val = DIGIT_MAX[W-1:0];
    assign rst_val = LOAD_VALUE[W-1:0];
    assign step    = tick & enable1 & enable2;
    assign at_max  = (count == max_val);
    assign at_zero = (count == '0);
    assign tc      = up ? at_max : at_zero;
    assign expired = (state == S_EXPIRED);

    // Ripple carry/borrow across digits; from terminal these naturally wrap.
    always_comb begin
        inc_val   = count;
        dec_val   = count;
        clamp_val = ld_data;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == max_val[4*i +: 4]) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = max_val[4*i +: 4];
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (ld_data[4*i +: 4] > max_val[4*i +: 4]) begin
                clamp_val[4*i +: 4] = max_val[4*i +: 4];
            end
        end
    end

    // flag remembers that done already fired for the terminal count currently held.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flag_nxt  = flag;
        done_nxt  = 1'b0;
        if (!loadN) begin
            state_nxt = S_RUN;
            count_nxt = clamp_val;
            flag_nxt  = 1'b0;
        end else if (step && state == S_RUN) begin
            if (!tc) begin
                count_nxt = up ? inc_val : dec_val;
                flag_nxt  = up ? (inc_val == max_val) : (dec_val == '0);
                done_nxt  = flag_nxt & ~done;
            end else if (WRAP) begin
                count_nxt = up ? inc_val : dec_val;
                flag_nxt  = 1'b0;
            end else begin
                state_nxt = S_EXPIRED;
                done_nxt  = ~flag & ~done;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= S_RUN;
            count <= rst_val;
            flag  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            flag  <= flag_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_timer_chain.sv
// Scoreboard bench: three configurations (saturating 6-digit, wrapping 6-digit, saturating 2-digit)
// share one stimulus stream; a mixed-radix integer model predicts every cycle's outputs.
module tb_bcd_timer_chain;

    localparam logic [31:0] DM0 = 32'h00995959;
    localparam logic [31:0] LV0 = 32'h00000100;
    localparam logic [31:0] DM2 = 32'h00000059;
    localparam logic [31:0] LV2 = 32'h00000030;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        loadN = 1'b1;
    logic [23:0] ld_data = '0;
    logic        enable1 = 1'b0;
    logic        enable2 = 1'b0;
    logic        tick = 1'b0;
    logic        up = 1'b1;

    logic [23:0] count0, count1;
    logic [7:0]  count2;
    logic [2:0]  tc_o, done_o, exp_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_timer_chain #(.DIGITS(6), .DIGIT_MAX(DM0), .LOAD_VALUE(LV0), .WRAP(1'b0)) u_sat (
        .clk(clk), .resetN(resetN), .loadN(loadN), .ld_data(ld_data),
        .enable1(enable1), .enable2(enable2), .tick(tick), .up(up),
        .count(count0), .tc(tc_o[0]), .done(done_o[0]), .expired(exp_o[0]));

    bcd_timer_chain #(.DIGITS(6), .DIGIT_MAX(DM0), .LOAD_VALUE(LV0), .WRAP(1'b1)) u_wrap (
        .clk(clk), .resetN(resetN), .loadN(loadN), .ld_data(ld_data),
        .enable1(enable1), .enable2(enable2), .tick(tick), .up(up),
        .count(count1), .tc(tc_o[1]), .done(done_o[1]), .expired(exp_o[1]));

    bcd_timer_chain #(.DIGITS(2), .DIGIT_MAX(DM2), .LOAD_VALUE(LV2), .WRAP(1'b0)) u_two (
        .clk(clk), .resetN(resetN), .loadN(loadN), .ld_data(ld_data[7:0]),
        .enable1(enable1), .enable2(enable2), .tick(tick), .up(up),
        .count(count2), .tc(tc_o[2]), .done(done_o[2]), .expired(exp_o[2]));

    // ---------------- reference model ----------------
    int ndig[3];
    int maxd[3][8];
    bit wrapc[3];
    logic [31:0] lval[3];
    int m_val[3];
    bit m_exp[3], m_flag[3], m_done[3];

    typedef struct packed {
        logic [23:0] c0;
        logic [23:0] c1;
        logic [7:0]  c2;
        logic [2:0]  tc;
        logic [2:0]  dn;
        logic [2:0]  ex;
    } exp_t;

    exp_t sbq[$];

    function automatic int weight(int k, int i);
        int w = 1;
        for (int j = 0; j < i; j++) w = w * (maxd[k][j] + 1);
        return w;
    endfunction

    function automatic int total(int k);
        return weight(k, ndig[k]);
    endfunction

    function automatic logic [31:0] to_bcd(int k, int v);
        logic [31:0] r = '0;
        int d;
        for (int i = 0; i < ndig[k]; i++) begin
            d = (v / weight(k, i)) % (maxd[k][i] + 1);
            r[4*i +: 4] = 4'(d);
        end
        return r;
    endfunction

    function automatic int from_bcd(int k, logic [31:0] data);
        int v = 0;
        int nib;
        for (int i = 0; i < ndig[k]; i++) begin
            nib = int'(data[4*i +: 4]);
            if (nib > maxd[k][i]) nib = maxd[k][i];
            v = v + nib * weight(k, i);
        end
        return v;
    endfunction

    function automatic bit at_term(int k, logic u);
        return u ? (m_val[k] == total(k) - 1) : (m_val[k] == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_val[k]  = from_bcd(k, lval[k]);
            m_exp[k]  = 1'b0;
            m_flag[k] = 1'b0;
            m_done[k] = 1'b0;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        logic [31:0] b;
        b = to_bcd(0, m_val[0]); e.c0 = b[23:0];
        b = to_bcd(1, m_val[1]); e.c1 = b[23:0];
        b = to_bcd(2, m_val[2]); e.c2 = b[7:0];
        for (int k = 0; k < 3; k++) begin
            e.tc[k] = at_term(k, up);
            e.dn[k] = m_done[k];
            e.ex[k] = m_exp[k];
        end
        sbq.push_back(e);
    endtask

    task automatic model_edge();
        bit t, nt, prev;
        int tot;
        for (int k = 0; k < 3; k++) begin
            tot  = total(k);
            t    = at_term(k, up);
            prev = m_done[k];
            m_done[k] = 1'b0;
            if (!loadN) begin
                m_val[k]  = from_bcd(k, {8'h00, ld_data});
                m_exp[k]  = 1'b0;
                m_flag[k] = 1'b0;
            end else if (tick && enable1 && enable2 && !m_exp[k]) begin
                if (!t) begin
                    m_val[k]  = up ? m_val[k] + 1 : m_val[k] - 1;
                    nt        = at_term(k, up);
                    m_flag[k] = nt;
                    m_done[k] = nt && !prev;
                end else if (wrapc[k]) begin
                    m_val[k]  = up ? 0 : tot - 1;
                    m_flag[k] = 1'b0;
                end else begin
                    m_exp[k]  = 1'b1;
                    m_done[k] = !m_flag[k] && !prev;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic rst, input logic ld, input logic [23:0] data,
                       input logic e1, input logic e2, input logic tk, input logic u);
        @(posedge clk);
        #1;
        resetN  = rst;
        loadN   = ld;
        ld_data = data;
        enable1 = e1;
        enable2 = e2;
        tick    = tk;
        up      = u;
        if (!rst) model_reset();
        push_expected();
        if (rst) model_edge();
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("count_sat",  32'(count0), 32'(e.c0));
                chk("count_wrap", 32'(count1), 32'(e.c1));
                chk("count_two",  32'(count2), 32'(e.c2));
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("tc%0d", k),      32'(tc_o[k]),   32'(e.tc[k]));
                    chk($sformatf("done%0d", k),    32'(done_o[k]), 32'(e.dn[k]));
                    chk($sformatf("expired%0d", k), 32'(exp_o[k]),  32'(e.ex[k]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] mp;
        logic [23:0] data;
        logic        cur_up;
        int r, sel;

        ndig  = '{6, 6, 2};
        wrapc = '{1'b0, 1'b1, 1'b0};
        lval  = '{LV0, LV0, LV2};
        for (int k = 0; k < 3; k++) begin
            mp = (k == 2) ? DM2 : DM0;
            for (int i = 0; i < 8; i++) maxd[k][i] = int'(mp[4*i +: 4]);
        end
        model_reset();

        cyc(0, 1, 24'h0,      0, 0, 0, 1);
        cyc(0, 1, 24'h0,      1, 1, 1, 1);
        cyc(1, 1, 24'h0,      1, 1, 0, 1);
        // up carry, then saturate at the top
        cyc(1, 0, 24'h005959, 1, 1, 0, 1);
        cyc(1, 1, 24'h0,      1, 1, 1, 1);
        cyc(1, 1, 24'h0,      1, 1, 0, 1);
        cyc(1, 0, 24'h995959, 1, 1, 0, 1);
        cyc(1, 1, 24'h0,      1, 1, 1, 1);
        cyc(1, 1, 24'h0,      1, 1, 1, 1);
        cyc(1, 1, 24'h0,      1, 1, 0, 1);
        cyc(1, 1, 24'h0,      1, 1, 0, 1);
        // countdown to zero, expiry without a second pulse, reload
        cyc(1, 0, 24'h000002, 1, 1, 0, 0);
        repeat (5) cyc(1, 1, 24'h0, 1, 1, 1, 0);
        cyc(1, 0, 24'h000030, 1, 1, 0, 0);
        cyc(1, 1, 24'h0,      1, 1, 0, 0);
        // terminal steps in both directions (wraps on the wrapping instance)
        cyc(1, 0, 24'h000000, 1, 1, 0, 0);
        cyc(1, 1, 24'h0,      1, 1, 1, 0);
        cyc(1, 0, 24'h995959, 1, 1, 0, 1);
        cyc(1, 1, 24'h0,      1, 1, 1, 1);
        cyc(1, 1, 24'h0,      1, 1, 0, 1);
        // gating, load beats step, clamp
        cyc(1, 0, 24'h001234, 1, 1, 0, 1);
        repeat (5) cyc(1, 1, 24'h0, 1, 0, 1, 1);
        repeat (2) cyc(1, 1, 24'h0, 0, 1, 1, 1);
        cyc(1, 0, 24'h000400, 1, 1, 1, 1);
        cyc(1, 0, 24'h007A8F, 1, 1, 0, 1);
        cyc(1, 1, 24'h0,      1, 1, 0, 1);
        // reset asserted while stepping
        cyc(1, 1, 24'h0,      1, 1, 1, 1);
        cyc(0, 1, 24'h0,      1, 1, 1, 1);
        cyc(1, 1, 24'h0,      1, 1, 0, 1);

        cur_up = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            r   = int'($urandom_range(0, 99));
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       data = 24'($urandom);
                1:       data = 24'h995958;
                2:       data = 24'h995959;
                3:       data = 24'h000001;
                4:       data = 24'h000000;
                default: data = 24'h005958;
            endcase
            if ($urandom_range(0, 19) == 0) cur_up = ~cur_up;
            cyc((r < 2) ? 1'b0 : 1'b1,
                (r >= 2 && r < 12) ? 1'b0 : 1'b1,
                data,
                ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                cur_up);
        end

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
